ysyx_25030085_idu: RTL and testbench
====================================

# ysyx_25030085_idu

Registered, parametrised instruction-decode stage for the NPC core, sitting between the IFU and the EXU. It accepts one fetched instruction per cycle over a valid/ready handshake and decodes it into a registered control bundle. A 2-entry skid buffer keeps full throughput under downstream back-pressure, and a flush input supports redirects. Exceptions are reported as bundle flags, not simulator callbacks, so the EXU/WBU commits them in order.

## Interface
- `XLEN`, 32: datapath width; only 32 or 64 are legal. 64 enables the RV64I W-ops, `ld`, `lwu` and `sd`.
- `PC_BASE`, 32'h8000_0000: instructions with `pc < PC_BASE` decode as a bubble, with all enables 0 and no exception flags.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: drops all buffered entries.
- `in_valid` input 1: IFU offers an instruction.
- `in_ready` output 1: IDU can accept.
- `in_inst` input 32: instruction word.
- `in_pc` input XLEN: instruction address.
- `out_valid` output 1: bundle valid.
- `out_ready` input 1: EXU accepts.
- `out_pc` output XLEN: passthrough of the instruction address.
- `out_rs1`, `out_rs2`, `out_rd` output 5 each: register indices. `out_rd` is forced to 0 when `rf_wen` = 0.
- `out_imm` output XLEN: sign-extended immediate. Shift immediates are zero-extended shamt.
- `out_alu_op` output 5, `out_alu_src` output 1, `out_alu_w` output 1: ALU control. `out_alu_w` selects the 32-bit W-op.
- `out_mem_ren`, `out_mem_wen` output 1 each; `out_mem_op` output 3: memory access control.
- `out_wb_sel` output 3, `out_rf_wen` output 1: write-back control.
- `out_branch` output 1, `out_br_fn` output 3, `out_jump` output 2: control flow. `out_br_fn` is `func3`; branches are resolved in the EXU, not here.
- `out_csr_op` output 2 (0 none, 1 write, 2 set); `out_csr_addr` output 12.
- `out_illegal`, `out_ebreak`, `out_ecall`, `out_mret` output 1 each: exception flags.

## Operation
- Decode is combinational from `in_inst`/`in_pc` into a bundle. The bundle is registered into the output register, or into the skid register when the output register is stalled.
- Encodings:
  - `wb_sel`: 0 ALU, 1 memory, 2 pc+4, 3 imm, 4 CSR.
  - `jump`: 1 jal, 2 jalr.
  - `mem_op`: 0 b, 1 h, 2 w, 3 d, 4 bu, 5 hu, 6 wu.
  - ALU op: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRA, 6 SRL, 7 OR, 8 AND, 9 PCADD, 10 SUB; 11–18 M-ext in `func3` order (MUL..REMU).
- Immediates: I, S, B, U and J formats, sign-extended to XLEN.
- Shift-immediate rules:
  - XLEN=32: `inst[25]`=1 is illegal.
  - XLEN=64: shamt is `inst[25:20]`.
  - W-shifts require `inst[25]`=0.
- Illegal: any unlisted opcode, `func3` or `func7` combination, or an RV64-only encoding when XLEN=32. Illegal decodes carry all enables 0, except `illegal`=1.
- SYSTEM opcode:
  - `func3`=0 with imm 0, 1 or 0x302 decodes to ecall, ebreak or mret.
  - `csrrw`/`csrrs` set `csr_op` and `rf_wen`=1 with `wb_sel`=4.
  - Anything else is illegal.
- Buffer state machine:
  - States: EMPTY, ONE (output register valid), TWO (output register and skid valid).
  - `in_ready` = (state != TWO).
  - A push (`in_valid & in_ready`) with no pop: EMPTY→ONE, ONE→TWO.
  - A pop (`out_valid & out_ready`) with no push: ONE→EMPTY, TWO→ONE; on TWO→ONE the skid entry moves to the output register.
  - Push and pop together in ONE: stay in ONE, and the new entry loads the output register.
- `flush`: next state is EMPTY, and any same-cycle push is dropped. `flush` has priority over every other event.

## Timing
- Latency: an instruction accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Stall: `out_*` hold stable while `out_valid & !out_ready`. No combinational path exists from `out_ready` to `in_ready`; `in_ready` is derived from registered state only.
- Reset (`rst_n`=0, asynchronous): state goes to EMPTY, `out_valid`=0, `in_ready`=1, and every bundle field is 0. Reset asserted mid-transfer discards both entries.
- After `rst_n` rises, the first push is accepted on the first clock edge.

## Configuration
- `YSYX_25030085_IDU_RVM_EN`:
  - When defined: OP/OP-32 with `func7`=0000001 decodes to M-ext ALU ops 11–18. With XLEN=64, OP-32 supports only MULW/DIVW/DIVUW/REMW/REMUW; other `func3` values are illegal.
  - When undefined: those encodings are illegal.

## Structure
- Package `ysyx_25030085_pkg` holds:
  - typedefs/constants for opcodes, ALU op, `mem_op`, `wb_sel`, `jump` and `csr_op`;
  - the packed `decode_bundle_t`, shared with the EXU.
- Sub-module `ysyx_25030085_idu_dec`: a purely combinational decoder, (`inst`, `pc`) → `decode_bundle_t`.
- `ysyx_25030085_idu` contains only the skid-buffer state machine and the registers.

## Test plan
- `addi x5,x0,-1` (0xFFF00293), XLEN=32 → next cycle: `imm`=0xFFFFFFFF, `alu_op`=0, `alu_src`=1, `rf_wen`=1, `rd`=5.
- Stream 4 instructions with `out_ready` low for cycles 2–3 → state reaches TWO, `in_ready`=0 for exactly one cycle, and all 4 emerge in order with none lost or duplicated.
- Push plus `flush` in the same cycle while in TWO → next cycle `out_valid`=0, `in_ready`=1, and nothing is emitted.
- `ebreak` (0x00100073) and 0xFFFFFFFF → `ebreak`=1; `illegal`=1 with `rf_wen`=`mem_wen`=0.
- `slli x1,x1,32` (0x02009093): XLEN=32 → `illegal`=1; XLEN=64 → `imm`=32.
- `mul x3,x1,x2` (0x022081B3) → `alu_op`=11 with the macro defined, `illegal`=1 without it. Additionally, `pc`=0x7FFFFFFC → bubble with all flags 0.

Source files
------------

// File: rtl/ysyx_25030085_pkg.sv
// Shared decode types for the NPC IDU/EXU.
// Holds opcode constants, control-field encodings and the packed decode
// bundle that travels from the IDU to the EXU. pc/imm are carried at the
// widest legal XLEN (64); consumers slice the low XLEN bits.
package ysyx_25030085_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SLL = 5'd1, ALU_SLT = 5'd2, ALU_SLTU = 5'd3,
    ALU_XOR = 5'd4, ALU_SRA = 5'd5, ALU_SRL = 5'd6, ALU_OR = 5'd7,
    ALU_AND = 5'd8, ALU_PCADD = 5'd9, ALU_SUB = 5'd10,
    ALU_MUL = 5'd11, ALU_MULH = 5'd12, ALU_MULHSU = 5'd13, ALU_MULHU = 5'd14,
    ALU_DIV = 5'd15, ALU_DIVU = 5'd16, ALU_REM = 5'd17, ALU_REMU = 5'd18
  } alu_op_e;

  // Load/store width; values line up with the RISC-V func3 field.
  typedef enum logic [2:0] {
    MEM_B = 3'd0, MEM_H = 3'd1, MEM_W = 3'd2, MEM_D = 3'd3,
    MEM_BU = 3'd4, MEM_HU = 3'd5, MEM_WU = 3'd6
  } mem_op_e;

  typedef enum logic [2:0] {
    WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2, WB_IMM = 3'd3, WB_CSR = 3'd4
  } wb_sel_e;

  typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_JAL = 2'd1, JMP_JALR = 2'd2} jump_e;
  typedef enum logic [1:0] {CSR_NONE = 2'd0, CSR_W = 2'd1, CSR_S = 2'd2} csr_op_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        alu_w;
    logic        mem_ren;
    logic        mem_wen;
    mem_op_e     mem_op;
    wb_sel_e     wb_sel;
    logic        rf_wen;
    logic        branch;
    logic [2:0]  br_fn;
    jump_e       jump;
    csr_op_e     csr_op;
    logic [11:0] csr_addr;
    logic        illegal;
    logic        ebreak;
    logic        ecall;
    logic        mret;
  } decode_bundle_t;

  // Base integer ALU op from func3; alt selects SRA over SRL.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030085_idu_dec.sv
// Combinational RV32I/RV64I (+optional M) decoder: (inst, pc) -> decode_bundle_t.
// Ports: i_inst instruction word, i_pc address (XLEN), o_bundle decoded fields.
// Build option: YSYX_25030085_IDU_RVM_EN enables the M-extension encodings.
// Illegal encodings clear every field except illegal; pc below PC_BASE
// yields an all-zero bubble (pc still passed through).
module ysyx_25030085_idu_dec
  import ysyx_25030085_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter logic [63:0] PC_BASE = 64'h0000_0000_8000_0000
) (
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output decode_bundle_t  o_bundle
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt, w_pc;
  logic        w_legal, w_w32;
  decode_bundle_t w_dec;

  assign w_op    = i_inst[6:0];
  assign w_f3    = i_inst[14:12];
  assign w_f7    = i_inst[31:25];
  assign w_w32   = (w_op == OP_OP32);
  assign w_pc    = 64'(i_pc);
  assign w_imm_i = {{52{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{52{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{51{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {{32{i_inst[31]}}, i_inst[31:12], 12'b0};
  assign w_imm_j = {{43{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  // inst[25] is part of shamt only on RV64; legality checks keep it 0 elsewhere.
  assign w_shamt = {58'b0, i_inst[25:20]};

  always_comb begin
    w_dec   = '0;
    w_legal = 1'b0;
    w_dec.rs1 = i_inst[19:15];
    w_dec.rs2 = i_inst[24:20];
    w_dec.rd  = i_inst[11:7];
    case (w_op)
      OP_LUI:   begin w_legal = 1'b1; w_dec.rf_wen = 1'b1; w_dec.wb_sel = WB_IMM; w_dec.alu_src = 1'b1; w_dec.imm = w_imm_u; end
      OP_AUIPC: begin w_legal = 1'b1; w_dec.rf_wen = 1'b1; w_dec.alu_op = ALU_PCADD; w_dec.alu_src = 1'b1; w_dec.imm = w_imm_u; end
      OP_JAL:   begin w_legal = 1'b1; w_dec.rf_wen = 1'b1; w_dec.jump = JMP_JAL; w_dec.wb_sel = WB_PC4; w_dec.imm = w_imm_j; end
      OP_JALR: begin
        w_legal = (w_f3 == 3'd0);
        w_dec.rf_wen = 1'b1; w_dec.jump = JMP_JALR; w_dec.wb_sel = WB_PC4;
        w_dec.alu_src = 1'b1; w_dec.imm = w_imm_i;
      end
      OP_BRANCH: begin
        w_legal = (w_f3 != 3'd2) && (w_f3 != 3'd3);
        w_dec.branch = 1'b1; w_dec.br_fn = w_f3; w_dec.imm = w_imm_b;
      end
      OP_LOAD: begin
        w_legal = (w_f3 != 3'd7) && (RV64 || ((w_f3 != 3'd3) && (w_f3 != 3'd6)));
        w_dec.mem_ren = 1'b1; w_dec.mem_op = mem_op_e'(w_f3); w_dec.rf_wen = 1'b1;
        w_dec.wb_sel = WB_MEM; w_dec.alu_src = 1'b1; w_dec.imm = w_imm_i;
      end
      OP_STORE: begin
        w_legal = (w_f3 <= 3'd2) || (RV64 && (w_f3 == 3'd3));
        w_dec.mem_wen = 1'b1; w_dec.mem_op = mem_op_e'(w_f3);
        w_dec.alu_src = 1'b1; w_dec.imm = w_imm_s;
      end
      OP_IMM: begin
        w_dec.rf_wen = 1'b1; w_dec.alu_src = 1'b1; w_dec.imm = w_imm_i;
        w_dec.alu_op = alu_from_f3(w_f3, i_inst[30]);
        case (w_f3)
          3'd1: begin
            w_legal   = (i_inst[31:26] == 6'b0) && (RV64 || !i_inst[25]);
            w_dec.imm = w_shamt;
          end
          3'd5: begin
            w_legal   = ((i_inst[31:26] == 6'b000000) || (i_inst[31:26] == 6'b010000)) && (RV64 || !i_inst[25]);
            w_dec.imm = w_shamt;
          end
          default: w_legal = 1'b1;
        endcase
      end
      OP_IMM32: begin
        w_dec.rf_wen = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu_w = 1'b1; w_dec.imm = w_imm_i;
        w_dec.alu_op = alu_from_f3(w_f3, i_inst[30]);
        case (w_f3)
          3'd0:    w_legal = RV64;
          3'd1:    begin w_legal = RV64 && (w_f7 == 7'b0); w_dec.imm = w_shamt; end
          3'd5:    begin w_legal = RV64 && ((w_f7 == 7'b0) || (w_f7 == 7'b0100000)); w_dec.imm = w_shamt; end
          default: w_legal = 1'b0;
        endcase
      end
      OP_OP, OP_OP32: begin
        w_dec.rf_wen = 1'b1; w_dec.alu_w = w_w32;
        case (w_f7)
          7'b0000000: begin
            w_dec.alu_op = alu_from_f3(w_f3, 1'b0);
            w_legal = !w_w32 || (w_f3 == 3'd0) || (w_f3 == 3'd1) || (w_f3 == 3'd5);
          end
          7'b0100000: begin
            w_dec.alu_op = (w_f3 == 3'd0) ? ALU_SUB : ALU_SRA;
            w_legal = (w_f3 == 3'd0) || (w_f3 == 3'd5);
          end
`ifdef YSYX_25030085_IDU_RVM_EN
          7'b0000001: begin
            w_dec.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(w_f3));
            w_legal = !w_w32 || (w_f3 == 3'd0) || (w_f3 >= 3'd4);
          end
`endif
          default: w_legal = 1'b0;
        endcase
        if (w_w32 && !RV64) w_legal = 1'b0;
      end
      OP_SYSTEM: begin
        case (w_f3)
          3'd0: begin
            w_legal = 1'b1;
            case (i_inst[31:20])
              12'h000: w_dec.ecall  = 1'b1;
              12'h001: w_dec.ebreak = 1'b1;
              12'h302: w_dec.mret   = 1'b1;
              default: w_legal = 1'b0;
            endcase
          end
          3'd1, 3'd2: begin
            w_legal = 1'b1;
            w_dec.csr_op   = (w_f3 == 3'd1) ? CSR_W : CSR_S;
            w_dec.rf_wen   = 1'b1;
            w_dec.wb_sel   = WB_CSR;
            w_dec.csr_addr = i_inst[31:20];
          end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_dec.rf_wen) w_dec.rd = 5'd0;
    if (!w_legal) begin
      w_dec = '0;
      w_dec.illegal = 1'b1;
    end
    if (w_pc < PC_BASE) w_dec = '0;
    w_dec.pc = w_pc;
  end

  assign o_bundle = w_dec;

endmodule

// File: rtl/ysyx_25030085_idu.sv
// NPC instruction-decode stage: decoder plus a 2-entry skid buffer.
// Upstream: i_in_valid/o_in_ready/i_in_inst/i_in_pc. Downstream: o_out_valid,
// i_out_ready and the registered decode fields o_out_*. i_flush drops both
// entries and any same-cycle push. o_in_ready depends on registered state only.
// Build option: YSYX_25030085_IDU_RVM_EN (M-extension decode, see decoder).
module ysyx_25030085_idu
  import ysyx_25030085_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter logic [63:0] PC_BASE = 64'h0000_0000_8000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_inst,
  input  logic [XLEN-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [4:0]      o_out_rs1,
  output logic [4:0]      o_out_rs2,
  output logic [4:0]      o_out_rd,
  output logic [XLEN-1:0] o_out_imm,
  output logic [4:0]      o_out_alu_op,
  output logic            o_out_alu_src,
  output logic            o_out_alu_w,
  output logic            o_out_mem_ren,
  output logic            o_out_mem_wen,
  output logic [2:0]      o_out_mem_op,
  output logic [2:0]      o_out_wb_sel,
  output logic            o_out_rf_wen,
  output logic            o_out_branch,
  output logic [2:0]      o_out_br_fn,
  output logic [1:0]      o_out_jump,
  output logic [1:0]      o_out_csr_op,
  output logic [11:0]     o_out_csr_addr,
  output logic            o_out_illegal,
  output logic            o_out_ebreak,
  output logic            o_out_ecall,
  output logic            o_out_mret
);
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]     r_state;
  decode_bundle_t r_out, r_skid, w_dec;
  logic           w_push, w_pop;

  ysyx_25030085_idu_dec #(.XLEN(XLEN), .PC_BASE(PC_BASE)) u_dec (
    .i_inst   (i_in_inst),
    .i_pc     (i_in_pc),
    .o_bundle (w_dec)
  );

  assign o_in_ready  = (r_state != S_TWO);
  assign o_out_valid = (r_state != S_EMPTY);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else if (i_flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_push) begin r_state <= S_ONE; r_out <= w_dec; end
        S_ONE: begin
          if (w_push && w_pop)  r_out <= w_dec;
          else if (w_push)      begin r_state <= S_TWO; r_skid <= w_dec; end
          else if (w_pop)       r_state <= S_EMPTY;
        end
        S_TWO:   if (w_pop) begin r_state <= S_ONE; r_out <= r_skid; end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign o_out_pc       = r_out.pc[XLEN-1:0];
  assign o_out_rs1      = r_out.rs1;
  assign o_out_rs2      = r_out.rs2;
  assign o_out_rd       = r_out.rd;
  assign o_out_imm      = r_out.imm[XLEN-1:0];
  assign o_out_alu_op   = r_out.alu_op;
  assign o_out_alu_src  = r_out.alu_src;
  assign o_out_alu_w    = r_out.alu_w;
  assign o_out_mem_ren  = r_out.mem_ren;
  assign o_out_mem_wen  = r_out.mem_wen;
  assign o_out_mem_op   = r_out.mem_op;
  assign o_out_wb_sel   = r_out.wb_sel;
  assign o_out_rf_wen   = r_out.rf_wen;
  assign o_out_branch   = r_out.branch;
  assign o_out_br_fn    = r_out.br_fn;
  assign o_out_jump     = r_out.jump;
  assign o_out_csr_op   = r_out.csr_op;
  assign o_out_csr_addr = r_out.csr_addr;
  assign o_out_illegal  = r_out.illegal;
  assign o_out_ebreak   = r_out.ebreak;
  assign o_out_ecall    = r_out.ecall;
  assign o_out_mret     = r_out.mret;

  // Upper halves of the 64-bit bundle fields are dead on RV32 builds.
  generate
    if (XLEN < 64) begin : g_rv32
      logic w_unused_hi;
      assign w_unused_hi = ^{r_out.pc[63:XLEN], r_out.imm[63:XLEN]};
    end
  endgenerate

endmodule

// File: tb/tb_ysyx_25030085_idu.sv
module tb_ysyx_25030085_idu;
  logic clk = 1'b0, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  int passed = 0, failed = 0, total = 0, nready = 0;
  logic [4:0] popped[$];

  // RV32 instance
  logic        in_ready, out_valid, alu_src, alu_w, mem_ren, mem_wen, rf_wen, branch, illegal, ebreak, ecall, mret;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd, alu_op;
  logic [2:0]  mem_op, wb_sel, br_fn;
  logic [1:0]  jump, csr_op;
  logic [11:0] csr_addr;
  // RV64 instance, same stimulus
  logic        in_ready64, out_valid64, alu_src64, alu_w64, mem_ren64, mem_wen64, rf_wen64, branch64, illegal64, ebreak64, ecall64, mret64;
  logic [63:0] out_pc64, imm64;
  logic [4:0]  rs1_64, rs2_64, rd64, alu_op64;
  logic [2:0]  mem_op64, wb_sel64, br_fn64;
  logic [1:0]  jump64, csr_op64;
  logic [11:0] csr_addr64;

  always #5 clk = ~clk;

  ysyx_25030085_idu #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_inst(in_inst), .i_in_pc(in_pc), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_pc(out_pc), .o_out_rs1(rs1), .o_out_rs2(rs2), .o_out_rd(rd), .o_out_imm(imm),
    .o_out_alu_op(alu_op), .o_out_alu_src(alu_src), .o_out_alu_w(alu_w), .o_out_mem_ren(mem_ren),
    .o_out_mem_wen(mem_wen), .o_out_mem_op(mem_op), .o_out_wb_sel(wb_sel), .o_out_rf_wen(rf_wen),
    .o_out_branch(branch), .o_out_br_fn(br_fn), .o_out_jump(jump), .o_out_csr_op(csr_op),
    .o_out_csr_addr(csr_addr), .o_out_illegal(illegal), .o_out_ebreak(ebreak), .o_out_ecall(ecall),
    .o_out_mret(mret));

  ysyx_25030085_idu #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready64),
    .i_in_inst(in_inst), .i_in_pc({32'h0, in_pc}), .o_out_valid(out_valid64), .i_out_ready(out_ready),
    .o_out_pc(out_pc64), .o_out_rs1(rs1_64), .o_out_rs2(rs2_64), .o_out_rd(rd64), .o_out_imm(imm64),
    .o_out_alu_op(alu_op64), .o_out_alu_src(alu_src64), .o_out_alu_w(alu_w64), .o_out_mem_ren(mem_ren64),
    .o_out_mem_wen(mem_wen64), .o_out_mem_op(mem_op64), .o_out_wb_sel(wb_sel64), .o_out_rf_wen(rf_wen64),
    .o_out_branch(branch64), .o_out_br_fn(br_fn64), .o_out_jump(jump64), .o_out_csr_op(csr_op64),
    .o_out_csr_addr(csr_addr64), .o_out_illegal(illegal64), .o_out_ebreak(ebreak64), .o_out_ecall(ecall64),
    .o_out_mret(mret64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Records pops and in_ready-low cycles as seen at the coming edge, then
  // advances to 1 time unit after that edge.
  task automatic tick();
    if (out_valid && out_ready) popped.push_back(rd);
    if (!in_ready) nready++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] insts [4];
    int idx, cyc;
    bit acc;
    insts[0] = 32'h00100093; insts[1] = 32'h00200113;
    insts[2] = 32'h00300193; insts[3] = 32'h00400213;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 32'h0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm, 0);
    chk("rst_rf_wen", rf_wen, 0);
    @(negedge clk) rst_n = 1'b1;

    // addi x5,x0,-1
    push(32'hFFF00293, 32'h8000_0000);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", imm, 32'hFFFF_FFFF);
    chk("addi_alu_op", alu_op, 0);
    chk("addi_alu_src", alu_src, 1);
    chk("addi_rf_wen", rf_wen, 1);
    chk("addi_rd", rd, 5);
    chk("addi_pc", out_pc, 32'h8000_0000);
    chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    // ebreak
    push(32'h00100073, 32'h8000_0004);
    chk("ebreak_flag", ebreak, 1);
    chk("ebreak_illegal", illegal, 0);
    chk("ebreak_rd", rd, 0);
    // all-ones word
    push(32'hFFFFFFFF, 32'h8000_0008);
    chk("ill_flag", illegal, 1);
    chk("ill_rf_wen", rf_wen, 0);
    chk("ill_mem_wen", mem_wen, 0);
    // slli x1,x1,32
    push(32'h02009093, 32'h8000_000C);
    chk("slli32_illegal", illegal, 1);
    chk("slli64_illegal", illegal64, 0);
    chk("slli64_imm", imm64, 32);
    chk("slli64_alu_op", alu_op64, 1);
    // lw x6,-4(x2)
    push(32'hFFC12303, 32'h8000_0010);
    chk("lw_mem_ren", mem_ren, 1);
    chk("lw_mem_op", mem_op, 2);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_imm", imm, 32'hFFFF_FFFC);
    chk("lw_rs1_rd", {rs1, rd}, {5'd2, 5'd6});
    // ld x6,-4(x2)
    push(32'hFFC13303, 32'h8000_0014);
    chk("ld32_illegal", illegal, 1);
    chk("ld32_mem_ren", mem_ren, 0);
    chk("ld64_mem_op", mem_op64, 3);
    chk("ld64_mem_ren", mem_ren64, 1);
    // sw x5,8(x1)
    push(32'h0050A423, 32'h8000_0018);
    chk("sw_mem_wen", mem_wen, 1);
    chk("sw_rd", rd, 0);
    chk("sw_imm", imm, 8);
    chk("sw_rs2", rs2, 5);
    // sub x1,x2,x3
    push(32'h403100B3, 32'h8000_001C);
    chk("sub_alu_op", alu_op, 10);
    chk("sub_rd", rd, 1);
    // csrrw x1,0x300,x2
    push(32'h300110F3, 32'h8000_0020);
    chk("csrrw_op", csr_op, 1);
    chk("csrrw_wb", wb_sel, 4);
    chk("csrrw_addr", csr_addr, 12'h300);
    chk("csrrw_rf_wen", rf_wen, 1);
    // jal x1,8
    push(32'h008000EF, 32'h8000_0024);
    chk("jal_jump", jump, 1);
    chk("jal_wb", wb_sel, 2);
    chk("jal_imm", imm, 8);
    // mul x3,x1,x2
    push(32'h022081B3, 32'h8000_0028);
`ifdef YSYX_25030085_IDU_RVM_EN
    chk("mul_alu_op", alu_op, 11);
    chk("mul_illegal", illegal, 0);
`else
    chk("mul_illegal", illegal, 1);
    chk("mul_alu_op", alu_op, 0);
`endif
    // bubble below PC_BASE
    push(32'hFFFFFFFF, 32'h7FFF_FFFC);
    chk("bub_valid", out_valid, 1);
    chk("bub_flags", {illegal, ebreak, ecall, mret, rf_wen, mem_wen, mem_ren}, 0);
    chk("bub_pc", out_pc, 32'h7FFF_FFFC);
    tick();
    chk("idle_valid", out_valid, 0);

    // Stream four instructions, downstream stalled for the first two edges.
    popped.delete(); nready = 0; idx = 0; cyc = 0;
    while ((idx < 4 || out_valid) && cyc < 20) begin
      out_ready = (cyc >= 2);
      in_valid  = (idx < 4);
      in_inst   = (idx < 4) ? insts[idx] : 32'h0;
      in_pc     = 32'h8000_0100 + 32'(4 * idx);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_bounded", cyc < 20, 1);
    chk("stream_count", popped.size(), 4);
    chk("stream_ready_low", nready, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("stream_order%0d", i), (popped.size() > i) ? popped[i] : 5'd31, 5'(i + 1));

    // Fill to TWO, then flush with a same-cycle push.
    out_ready = 1'b0;
    push(insts[0], 32'h8000_0200);
    push(insts[1], 32'h8000_0204);
    chk("two_in_ready", in_ready, 0);
    flush = 1'b1; in_valid = 1'b1; in_inst = insts[2];
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    popped.delete(); out_ready = 1'b1;
    tick(); tick(); tick();
    chk("flush_no_emit", popped.size(), 0);
    // Flush with a push from EMPTY.
    flush = 1'b1;
    push(insts[3], 32'h8000_0300);
    flush = 1'b0;
    chk("flush_empty_push", out_valid, 0);

    // Asynchronous reset while holding two entries.
    out_ready = 1'b0;
    push(insts[0], 32'h8000_0400);
    push(insts[1], 32'h8000_0404);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_imm", imm, 0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    push(insts[2], 32'h8000_0500);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_rd", rd, 3);
    tick();
    chk("post_rst_drain", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
